// File: rtl/store_buffer_if.sv
// Pipeline/memory-side bundle of the posted-write store buffer.
// The store buffer takes the slave view; the pipeline+memory environment takes the master view.
interface store_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              st_valid;
    logic [ADDR_W-1:0] st_addr;
    logic [DATA_W-1:0] st_data;
    logic              st_ready;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              stall;
    logic              mem_write;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        input  st_ready, ld_data, stall, mem_write, mem_read, mem_addr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, ld_req, ld_addr, mem_rdata,
        output st_ready, ld_data, stall, mem_write, mem_read, mem_addr, mem_wdata
    );
endinterface

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of stores drained on idle memory cycles, loads win the port.
// Define STORE_FWD_EN to forward buffered stores to loads; otherwise loads stall until the buffer drains.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    store_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] entry_addr [DEPTH];
    logic [DATA_W-1:0] entry_data [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;

    logic              enq;
    logic              drain;
    logic              load_go;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    assign bus.st_ready = (count < CNT_W'(DEPTH));
    assign enq          = bus.st_valid & bus.st_ready;

`ifdef STORE_FWD_EN
    assign load_go = bus.ld_req;
    assign drain   = ~bus.ld_req & (count != '0);

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (entry_addr[head + PTR_W'(i)] == bus.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = entry_data[head + PTR_W'(i)];
            end
        end
    end
`else
    // Without forwarding a pending load forces the buffer to empty before it may read memory.
    assign load_go  = bus.ld_req & (count == '0);
    assign drain    = (count != '0);
    assign fwd_hit  = 1'b0;
    assign fwd_data = '0;
`endif

    assign bus.stall = (bus.st_valid & ~bus.st_ready) | (bus.ld_req & ~load_go);

    always_comb begin
        bus.mem_write = drain;
        bus.mem_read  = load_go;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.ld_data   = '0;
        if (load_go) begin
            bus.mem_addr = bus.ld_addr;
            bus.ld_data  = fwd_hit ? fwd_data : bus.mem_rdata;
        end else if (drain) begin
            bus.mem_addr  = entry_addr[head];
            bus.mem_wdata = entry_data[head];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({enq, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: payload storage is not reset; validity comes from head/count, so stale data is never visible.
    always_ff @(posedge clk) begin
        if (enq) begin
            entry_addr[tail] <= bus.st_addr;
            entry_data[tail] <= bus.st_data;
        end
    end

    a_port_exclusive: assert property (@(posedge clk) disable iff (reset)
        !(bus.mem_write && bus.mem_read));
    a_count_bound: assert property (@(posedge clk) disable iff (reset)
        count <= CNT_W'(DEPTH));
endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  count;
    int          total = 0;
    int          bad   = 0;

    store_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .count (count)
    );

    always #5 clk = ~clk;

    // Data memory environment: 16 words indexed by the low address bits, combinational read.
    logic [31:0] phys_mem [16];
    assign bus.mem_rdata = bus.mem_read ? phys_mem[bus.mem_addr[3:0]] : '0;
    always @(posedge clk) if (bus.mem_write) phys_mem[bus.mem_addr[3:0]] <= bus.mem_wdata;

    // Reference model: program-ordered queue of pending stores and the memory image they produce.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    store_t      pend[$];
    logic [31:0] ref_mem [16];

    logic        e_ready, e_stall, e_write, e_read, e_drain, cur_sv;
    logic [31:0] e_addr, e_wdata, e_ld, cur_sa, cur_sd;
    logic [2:0]  e_count;

    task automatic apply(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                         input logic lr, input logic [31:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_req   = lr;
        bus.ld_addr  = la;
        cur_sv = sv;
        cur_sa = sa;
        cur_sd = sd;
        #1;
        e_count = 3'(pend.size());
        e_ready = pend.size() < DEPTH;
`ifdef STORE_FWD_EN
        e_read  = lr;
        e_drain = !lr && pend.size() > 0;
`else
        e_read  = lr && pend.size() == 0;
        e_drain = pend.size() > 0;
`endif
        e_stall = (sv && !e_ready) || (lr && !e_read);
        e_write = e_drain;
        e_addr  = '0;
        e_wdata = '0;
        e_ld    = '0;
        if (e_read) begin
            e_addr = la;
            e_ld   = ref_mem[la[3:0]];
            foreach (pend[i]) if (pend[i].addr == la) e_ld = pend[i].data;
        end else if (e_drain) begin
            e_addr  = pend[0].addr;
            e_wdata = pend[0].data;
        end
    endtask

    task automatic tick();
        store_t s;
        @(posedge clk);
        if (e_drain) begin
            s = pend.pop_front();
            ref_mem[s.addr[3:0]] = s.data;
        end
        if (cur_sv && e_ready) begin
            s.addr = cur_sa;
            s.data = cur_sd;
            pend.push_back(s);
        end
        @(negedge clk);
    endtask

    function automatic logic [70:0] dut_vec();
        return {bus.st_ready, bus.stall, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, count};
    endfunction

    function automatic logic [70:0] model_vec();
        return {e_ready, e_stall, e_write, e_read, e_addr, e_wdata, e_count};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        apply(1'b0, '0, '0, 1'b0, '0);
        total++;
        if (dut_vec() !== 71'({1'b1, 70'b0})) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", dut_vec(), 71'({1'b1, 70'b0}));
        end
        total++;
        if (bus.ld_data !== 32'h0) begin
            bad++;
            $display("FAIL reset_ld_data: got %h want 0", bus.ld_data);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_drain_order();
        logic [31:0] sa [4] = '{32'h4, 32'h8, 32'h0, 32'h0};
        logic [31:0] sd [4] = '{32'h11, 32'h22, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            apply(i < 2, sa[i], sd[i], 1'b0, '0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL drain_order step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_no_match();
        logic [31:0] sa [4] = '{32'h7, 32'h1000_0007, 32'h0, 32'h0};
        logic [31:0] la [4] = '{32'h2, 32'h2, 32'h7, 32'h2};
        for (int i = 0; i < 4; i++) begin
            apply(i < 2, sa[i], 32'hC0DE_0000 + 32'(i), 1'b1, la[i]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL no_match step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (e_read) begin
                total++;
                if (bus.ld_data !== e_ld) begin
                    bad++;
                    $display("FAIL no_match_ld step %0d: got %h want %h", i, bus.ld_data, e_ld);
                end
            end
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, '0, '0, 1'b0, '0);
            tick();
        end
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 9; i++) begin
            if (i < 5) apply(1'b1, 32'd12 + 32'(i % 4), $urandom, 1'b1, 32'h30);
            else       apply(1'b0, '0, '0, 1'b0, '0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL fill_full step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (e_read) begin
                total++;
                if (bus.ld_data !== e_ld) begin
                    bad++;
                    $display("FAIL fill_full_ld step %0d: got %h want %h", i, bus.ld_data, e_ld);
                end
            end
            tick();
        end
    endtask

    task automatic test_forward();
        logic        sv [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [31:0] sd [7] = '{32'hAA, 32'hBB, 32'h0, 32'hCC, 32'h0, 32'h0, 32'h0};
        logic [31:0] la [7] = '{32'h9, 32'h9, 32'h5, 32'h5, 32'h5, 32'h5, 32'h5};
        for (int i = 0; i < 7; i++) begin
            apply(sv[i], 32'h5, sd[i], 1'b1, la[i]);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL forward step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (e_read) begin
                total++;
                if (bus.ld_data !== e_ld) begin
                    bad++;
                    $display("FAIL forward_ld step %0d: got %h want %h", i, bus.ld_data, e_ld);
                end
            end
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, '0, '0, 1'b0, '0);
            tick();
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 12; i++) begin
            if (i < 2)      apply(1'b1, 32'h20 + 32'(i), $urandom, 1'b1, 32'h40);
            else if (i < 9) apply(1'b1, 32'h20 + 32'(i), $urandom, 1'b0, '0);
            else            apply(1'b0, '0, '0, 1'b0, '0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL wrap step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        logic        sv, lr;
        logic [31:0] sa, la;
        for (int i = 0; i < 400; i++) begin
            sv = ($urandom_range(0, 1) == 1);
            lr = ($urandom_range(0, 9) < 3);
            sa = 32'($urandom_range(0, 7));
            la = 32'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) sa = sa | 32'h8000_0000;
            apply(sv, sa, $urandom, lr, la);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL random cycle %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            if (e_read) begin
                total++;
                if (bus.ld_data !== e_ld) begin
                    bad++;
                    $display("FAIL random_ld cycle %0d: got %h want %h", i, bus.ld_data, e_ld);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] snap [16];
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 32'h1 + 32'(i), $urandom, 1'b1, 32'h3);
            tick();
        end
        apply(1'b0, '0, '0, 1'b0, '0);
        total++;
        if (dut_vec() !== model_vec()) begin
            bad++;
            $display("FAIL pre_reset: got %h want %h", dut_vec(), model_vec());
        end
        snap = phys_mem;
        reset = 1'b1;
        #1;
        total++;
        if ({count, bus.mem_write} !== 4'b0) begin
            bad++;
            $display("FAIL async_reset: got count=%0d mem_write=%b want 0/0", count, bus.mem_write);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        pend.delete();
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, '0, '0, 1'b0, '0);
            total++;
            if (dut_vec() !== model_vec()) begin
                bad++;
                $display("FAIL post_reset step %0d: got %h want %h", i, dut_vec(), model_vec());
            end
            tick();
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (phys_mem[i] !== snap[i]) begin
                bad++;
                $display("FAIL reset_no_write word %0d: got %h want %h", i, phys_mem[i], snap[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            phys_mem[i] = 32'(i) ^ 32'h0D;
            ref_mem[i]  = 32'(i) ^ 32'h0D;
        end
        test_reset();
        test_drain_order();
        test_no_match();
        test_fill_full();
        test_forward();
        test_wrap();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
